itcm_port_arbiter: RTL and testbench
====================================

// Module: itcm_port_arbiter
// PURPOSE
//  Shares the single-port instruction TCM between the fetch stage and the data-side load/store port.
//  - Grants one requester per cycle and drives the SRAM.
//  - Routes the 1-cycle-latency read data back to the owner.
//  - Default priority is data; a starvation counter guarantees fetch progress.
//  - Sits between the fetch next_pc/instr_read_data interface and the ITCM macro.
// PARAMETERS
//  ADDR_WIDTH  32  byte address width of both requesters
//  DATA_WIDTH  32  SRAM word width
//  MEM_AW      14  SRAM word-address width; mem_addr = addr[MEM_AW+1:2]
//  STARVE_MAX  4   max consecutive contended cycles fetch may lose before it is forced to win
// PORTS
//  cpu_clk                in   1           core clock; all state updates on rising edge
//  cpu_rst                in   1           reset, synchronous, active-high
//  fetch_req              in   1           fetch wants a word at fetch_addr
//  fetch_addr             in   ADDR_WIDTH  fetch address (next_pc)
//  fetch_gnt              out  1           fetch request accepted this cycle
//  fetch_flush            in   1           jump/branch/trap/mret: discard fetch data returning this cycle
//  instr_read_data_valid  out  1           fetch read data valid
//  instr_read_data        out  DATA_WIDTH  fetch read data
//  data_req               in   1           data-side access request
//  data_we                in   1           1 = write, 0 = read
//  data_be                in   4           byte enables (writes only)
//  data_addr              in   ADDR_WIDTH  data byte address
//  data_wdata             in   DATA_WIDTH  write data
//  data_gnt               out  1           data request accepted this cycle
//  data_rvalid            out  1           data read data valid
//  data_rdata             out  DATA_WIDTH  data read data
//  mem_cs                 out  1           SRAM chip select
//  mem_we                 out  1           SRAM write enable
//  mem_be                 out  4           SRAM byte enables (4'hF on reads)
//  mem_addr               out  MEM_AW      SRAM word address
//  mem_wdata              out  DATA_WIDTH  SRAM write data
//  mem_rdata              in   DATA_WIDTH  SRAM read data, valid the cycle after a read select
// BEHAVIOUR
//  Reset (cpu_rst=1):
//   - fetch_gnt, data_gnt, mem_cs, instr_read_data_valid and data_rvalid are all 0.
//   - resp_state = IDLE; starve_cnt = 0.
//   - Any read already in flight is dropped: no rvalid is issued in the cycle after reset deasserts.
//  Grant (combinational, same cycle as the request):
//   - Only one requester -> that requester wins.
//   - Both requesting -> data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
//   - The winner's gnt = 1 and mem_* are driven from the winner.
//   - mem_cs = fetch_gnt | data_gnt; mem_we = data_gnt & data_we.
//   - Fetch accesses are always reads.
//  starve_cnt, width $clog2(STARVE_MAX+1):
//   - Clears when fetch_gnt = 1 or fetch_req = 0.
//   - Increments when fetch_req & !fetch_gnt; saturates at STARVE_MAX.
//  Response FSM resp_state (registered owner of the read in the SRAM pipe):
//   - IDLE       : next = RESP_FETCH if fetch_gnt; RESP_DATA if data_gnt & !data_we; else IDLE.
//   - RESP_FETCH : instr_read_data_valid = !fetch_flush; instr_read_data = mem_rdata.
//                  Next state is chosen from this cycle's grant, same rules as IDLE.
//   - RESP_DATA  : data_rvalid = 1; data_rdata = mem_rdata. Next state as IDLE.
//   - Back-to-back grants give one valid every cycle.
//  Latencies and data:
//   - Read latency is exactly 1 cycle from grant to rvalid.
//   - Writes complete at grant and produce no rvalid.
//   - A write never delays a following read.
//   - When the matching valid is 0, instr_read_data and data_rdata are 0.
//  fetch_flush:
//   - Suppresses only the fetch response returning in the flush cycle.
//   - A fetch granted in the flush cycle (the redirected target) returns normally.
//  Address and request rules:
//   - Low two address bits are ignored; no alignment checking (pc_misaligned is raised in fetch).
//   - Requesters hold req/addr stable until gnt.
//   - Request signals are never qualified by rvalid.
// TESTING
//  T1 Fetch only:
//     fetch_req=1, addr 0x0,0x4,0x8 back-to-back
//     -> fetch_gnt=1 each cycle; mem_addr 0,1,2; valid 1 cycle later with mem_rdata words.
//  T2 Contention (STARVE_MAX=4):
//     both req held 6 cycles
//     -> grants D,D,D,D,F,D; starve_cnt 1,2,3,4,0,1; rvalids routed to the matching owner.
//  T3 Write then read:
//     data write be=4'b0011 addr 0x10, then read 0x10
//     -> mem_we=1 be=0011 addr 4; no rvalid for the write; data_rvalid 1 cycle after the read grant.
//  T4 Flush:
//     fetch granted at cycle N, fetch_flush=1 at N+1 with a new fetch granted at N+1
//     -> instr_read_data_valid=0 at N+1, =1 at N+2.
//  T5 Reset mid-read:
//     data read granted, cpu_rst=1 on the next edge
//     -> data_rvalid stays 0; after release all gnt/valid=0 until a new req.
//  T6 Idle: no req -> mem_cs=0, resp_state stays IDLE, starve_cnt=0.

Source files
------------

// File: rtl/itcm_port_arbiter.sv
// Single-port ITCM arbiter: data side wins by default, fetch is forced through after STARVE_MAX lost cycles.
// Grant is combinational; read data returns exactly one cycle after grant and is routed to the owner.
module itcm_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_gnt,
    input  logic                  fetch_flush,
    output logic                  instr_read_data_valid,
    output logic [DATA_WIDTH-1:0] instr_read_data,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [3:0]            data_be,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_gnt,
    output logic                  data_rvalid,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RESP_FETCH = 2'd1,
        RESP_DATA  = 2'd2
    } resp_state_t;

    resp_state_t   resp_state;
    resp_state_t   resp_next;
    logic [SW-1:0] starve_cnt;
    logic          starved;

    // Only the word-address slice is consumed; byte offset and upper bits are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch_addr[ADDR_WIDTH-1:MEM_AW+2], fetch_addr[1:0],
                                data_addr[ADDR_WIDTH-1:MEM_AW+2], data_addr[1:0]};

    assign starved = (starve_cnt == SW'(STARVE_MAX));

    always_comb begin
        fetch_gnt = 1'b0;
        data_gnt  = 1'b0;
        if (!cpu_rst) begin
            if (data_req && !(fetch_req && starved)) begin
                data_gnt = 1'b1;
            end else if (fetch_req) begin
                fetch_gnt = 1'b1;
            end
        end
    end

    assign mem_cs    = fetch_gnt | data_gnt;
    assign mem_we    = data_gnt & data_we;
    assign mem_be    = mem_we ? data_be : 4'hF;
    assign mem_addr  = data_gnt ? data_addr[MEM_AW+1:2] : fetch_addr[MEM_AW+1:2];
    assign mem_wdata = mem_we ? data_wdata : '0;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            starve_cnt <= '0;
        end else if (fetch_gnt || !fetch_req) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Every state picks its successor from the current grant, so back-to-back reads stream.
    always_comb begin
        resp_next = IDLE;
        if (fetch_gnt) begin
            resp_next = RESP_FETCH;
        end else if (data_gnt && !data_we) begin
            resp_next = RESP_DATA;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            resp_state <= IDLE;
        end else begin
            resp_state <= resp_next;
        end
    end

    // Gating with cpu_rst drops a read that was in flight when reset arrived.
    assign instr_read_data_valid = !cpu_rst && (resp_state == RESP_FETCH) && !fetch_flush;
    assign instr_read_data       = instr_read_data_valid ? mem_rdata : '0;
    assign data_rvalid           = !cpu_rst && (resp_state == RESP_DATA);
    assign data_rdata            = data_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_itcm_port_arbiter.sv
// Directed bench for itcm_port_arbiter with a small behavioural SRAM behind it.
module tb_itcm_port_arbiter;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_flush;
    logic        instr_read_data_valid;
    logic [31:0] instr_read_data;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        mem_cs;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 cpu_clk = ~cpu_clk;

    itcm_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_AW(14), .STARVE_MAX(4)
    ) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_flush(fetch_flush),
        .instr_read_data_valid(instr_read_data_valid), .instr_read_data(instr_read_data),
        .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge cpu_clk) begin
        if (mem_cs && !mem_we) begin
            mem_rdata <= mem[mem_addr[5:0]];
        end
        if (mem_cs && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; checks run 2ns later, well clear of the rising edge.
    task automatic next_cycle();
        @(negedge cpu_clk);
    endtask

    task automatic settle();
        #2;
    endtask

    // Contention schedule with STARVE_MAX=4: 1 = data wins, 0 = fetch wins.
    logic       exp_dwin [0:5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0] exp_cnt  [0:5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem_rdata   = 32'h0;
        cpu_rst     = 1'b1;
        fetch_req   = 1'b1;
        fetch_addr  = 32'h0;
        fetch_flush = 1'b0;
        data_req    = 1'b1;
        data_we     = 1'b0;
        data_be     = 4'h0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;

        // Reset with both requests raised: nothing may be granted.
        next_cycle(); next_cycle(); settle();
        chk("rst_fetch_gnt", 64'(fetch_gnt), 64'd0);
        chk("rst_data_gnt",  64'(data_gnt),  64'd0);
        chk("rst_mem_cs",    64'(mem_cs),    64'd0);
        chk("rst_ivalid",    64'(instr_read_data_valid), 64'd0);
        chk("rst_dvalid",    64'(data_rvalid), 64'd0);
        chk("rst_cnt",       64'(dut.starve_cnt), 64'd0);

        // T1: fetch-only stream of three words.
        next_cycle();
        cpu_rst = 1'b0; data_req = 1'b0; fetch_addr = 32'h0; settle();
        chk("t1_gnt0",  64'(fetch_gnt), 64'd1);
        chk("t1_addr0", 64'(mem_addr),  64'd0);
        chk("t1_iv0",   64'(instr_read_data_valid), 64'd0);
        next_cycle(); fetch_addr = 32'h4; settle();
        chk("t1_addr1", 64'(mem_addr), 64'd1);
        chk("t1_iv1",   64'(instr_read_data_valid), 64'd1);
        chk("t1_dat1",  64'(instr_read_data), 64'h1000_0000);
        next_cycle(); fetch_addr = 32'h8; settle();
        chk("t1_addr2", 64'(mem_addr), 64'd2);
        chk("t1_dat2",  64'(instr_read_data), 64'h1000_0001);
        next_cycle(); fetch_req = 1'b0; settle();
        chk("t1_cs_off", 64'(mem_cs), 64'd0);
        chk("t1_dat3",   64'(instr_read_data), 64'h1000_0002);
        next_cycle(); settle();
        chk("t1_iv_off",  64'(instr_read_data_valid), 64'd0);
        chk("t1_dat_off", 64'(instr_read_data), 64'd0);

        // T2: both requesters held for six cycles.
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            fetch_req = 1'b1; fetch_addr = 32'h20;
            data_req  = 1'b1; data_addr  = 32'h40; data_we = 1'b0;
            settle();
            chk($sformatf("t2_dgnt%0d", i), 64'(data_gnt),  64'(exp_dwin[i]));
            chk($sformatf("t2_fgnt%0d", i), 64'(fetch_gnt), 64'(!exp_dwin[i]));
            chk($sformatf("t2_cnt%0d", i),  64'(dut.starve_cnt), 64'(exp_cnt[i]));
            chk($sformatf("t2_addr%0d", i), 64'(mem_addr), exp_dwin[i] ? 64'd16 : 64'd8);
            if (i > 0) begin
                chk($sformatf("t2_dv%0d", i), 64'(data_rvalid), 64'(exp_dwin[i-1]));
                chk($sformatf("t2_iv%0d", i), 64'(instr_read_data_valid), 64'(!exp_dwin[i-1]));
                chk($sformatf("t2_rd%0d", i), 64'(data_rdata | instr_read_data),
                    exp_dwin[i-1] ? 64'h1000_0010 : 64'h1000_0008);
            end
        end
        next_cycle(); fetch_req = 1'b0; data_req = 1'b0; settle();
        chk("t2_cnt_last", 64'(dut.starve_cnt), 64'd1);
        chk("t2_dv_last",  64'(data_rvalid), 64'd1);
        chk("t2_rd_last",  64'(data_rdata), 64'h1000_0010);

        // T3: partial write then read of the same word.
        next_cycle();
        data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
        data_addr = 32'h10; data_wdata = 32'hDEAD_BEEF; settle();
        chk("t3_wgnt", 64'(data_gnt), 64'd1);
        chk("t3_we",   64'(mem_we),   64'd1);
        chk("t3_be",   64'(mem_be),   64'h3);
        chk("t3_addr", 64'(mem_addr), 64'd4);
        chk("t3_wdat", 64'(mem_wdata), 64'hDEAD_BEEF);
        next_cycle(); data_we = 1'b0; settle();
        chk("t3_rgnt",   64'(data_gnt), 64'd1);
        chk("t3_rd_be",  64'(mem_be),   64'hF);
        chk("t3_no_rv",  64'(data_rvalid), 64'd0);
        next_cycle(); data_req = 1'b0; settle();
        chk("t3_rv",    64'(data_rvalid), 64'd1);
        chk("t3_rdata", 64'(data_rdata),  64'h1000_BEEF);

        // T4: flush kills the returning word, the redirected fetch returns.
        next_cycle(); fetch_req = 1'b1; fetch_addr = 32'h0; settle();
        chk("t4_gnt_n", 64'(fetch_gnt), 64'd1);
        next_cycle(); fetch_addr = 32'h40; fetch_flush = 1'b1; settle();
        chk("t4_gnt_n1", 64'(fetch_gnt), 64'd1);
        chk("t4_iv_n1",  64'(instr_read_data_valid), 64'd0);
        chk("t4_dat_n1", 64'(instr_read_data), 64'd0);
        next_cycle(); fetch_req = 1'b0; fetch_flush = 1'b0; settle();
        chk("t4_iv_n2",  64'(instr_read_data_valid), 64'd1);
        chk("t4_dat_n2", 64'(instr_read_data), 64'h1000_0010);

        // T5: reset lands on the cycle the granted read would return.
        next_cycle(); data_req = 1'b1; data_we = 1'b0; data_addr = 32'h8; settle();
        chk("t5_gnt", 64'(data_gnt), 64'd1);
        next_cycle(); data_req = 1'b0; cpu_rst = 1'b1; settle();
        chk("t5_rv_rst", 64'(data_rvalid), 64'd0);
        next_cycle(); cpu_rst = 1'b0; settle();
        chk("t5_rv_after", 64'(data_rvalid), 64'd0);
        chk("t5_iv_after", 64'(instr_read_data_valid), 64'd0);
        chk("t5_gnt_after", 64'({fetch_gnt, data_gnt}), 64'd0);

        // T6: idle.
        for (int i = 0; i < 2; i++) begin
            next_cycle(); settle();
            chk($sformatf("t6_cs%0d", i),    64'(mem_cs), 64'd0);
            chk($sformatf("t6_state%0d", i), 64'(dut.resp_state), 64'd0);
            chk($sformatf("t6_cnt%0d", i),   64'(dut.starve_cnt), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
